seq_alu: RTL and testbench



---
 rtl/seq_alu.sv | 185 ++++++++++++++++++
 tb/tb_seq_alu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU: single-cycle logic/arithmetic/compare ops plus
// iterative unsigned shift-add multiply and restoring divide.
module seq_alu #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUctrl,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             Zero,
    output logic             Overflow
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               loaded;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] step;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   sum, diff;
    logic [WIDTH-1:0]   alu_res, alu_hi;
    logic               alu_ovf;
    logic               ovf;
    logic               accept;

    assign accept = in_valid && (state == IDLE);
    assign sum    = input1 + input2;
    assign diff   = input1 - input2;

    // Single-cycle result computed straight from the operand inputs so it
    // can be registered on the accept edge.
    always_comb begin
        alu_res = '0;
        alu_hi  = '0;
        alu_ovf = 1'b0;
        case (ALUctrl)
            OP_AND:  alu_res = input1 & input2;
            OP_OR:   alu_res = input1 | input2;
            OP_NOR:  alu_res = ~(input1 | input2);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                          (sum[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                          (diff[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (input1 < input2)};
            OP_DIVU: begin
                alu_res = '1;
                alu_hi  = input1;
            end
            default: ;
        endcase
    end

    // prod holds {acc, multiplier} for MUL and {remainder, quotient} for DIV.
    assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    assign div_diff = prod[2*WIDTH-1:WIDTH-1] - {1'b0, operand};

    always_comb begin
        step = '0;
        if (state == DIV) begin
            if (div_diff[WIDTH])
                step = {prod[2*WIDTH-2:0], 1'b0};
            else
                step = {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
        end else begin
            if (prod[0])
                step = {mul_sum, prod[WIDTH-1:1]};
            else
                step = {1'b0, prod[2*WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (ALUctrl == OP_MUL)
                        state_nxt = MUL;
                    else if (ALUctrl == OP_DIVU && input2 != '0)
                        state_nxt = DIV;
                    else
                        state_nxt = DONE;
                end
            end
            MUL, DIV: if (loaded && cnt == '0) state_nxt = DONE;
            DONE:     if (out_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // The first busy cycle only stages the operands, so the final iteration
    // and result write land WIDTH+1 edges after the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out     <= '0;
            out_hi  <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
            loaded  <= 1'b0;
            operand <= '0;
            prod    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= CNT_W'(WIDTH - 1);
                        loaded <= 1'b0;
                        if (ALUctrl == OP_MUL) begin
                            operand <= input1;
                            prod    <= {{WIDTH{1'b0}}, input2};
                            ovf     <= 1'b0;
                        end else if (ALUctrl == OP_DIVU && input2 != '0) begin
                            operand <= input2;
                            prod    <= {{WIDTH{1'b0}}, input1};
                            ovf     <= 1'b0;
                        end else begin
                            out    <= alu_res;
                            out_hi <= alu_hi;
                            ovf    <= alu_ovf;
                        end
                    end
                end
                MUL, DIV: begin
                    if (!loaded) begin
                        loaded <= 1'b1;
                    end else begin
                        prod <= step;
                        if (cnt == '0) begin
                            out    <= step[WIDTH-1:0];
                            out_hi <= step[2*WIDTH-1:WIDTH];
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign Zero     = (out == '0);
    assign Overflow = ovf;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32) using immediate
// assertions at every comparison point.
module tb_seq_alu;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUctrl;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    logic             Zero;
    logic             Overflow;

    int compared   = 0;
    int mismatched = 0;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUctrl   (ALUctrl),
        .input1    (input1),
        .input2    (input2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_hi    (out_hi),
        .Zero      (Zero),
        .Overflow  (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one operation and returns #1 after the accept edge.
    task automatic applyStimulus(input logic [3:0] ctrl, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        ALUctrl  = ctrl;
        input1   = a;
        input2   = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges until out_valid, checking in_ready stays low while busy.
    task automatic waitValid(output int lat, output logic readySeen);
        lat       = 0;
        readySeen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) readySeen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic singleOp(input string tag, input logic [3:0] ctrl,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] expOut, input logic [WIDTH-1:0] expHi,
                            input logic expZero, input logic expOvf);
        applyStimulus(ctrl, a, b);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_out"}, 64'(out), 64'(expOut));
        checkOutput({tag, "_hi"}, 64'(out_hi), 64'(expHi));
        checkOutput({tag, "_zero"}, 64'(Zero), 64'(expZero));
        checkOutput({tag, "_ovf"}, 64'(Overflow), 64'(expOvf));
        @(posedge clk);
        #1;
        checkOutput({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    int   lat;
    logic readySeen;
    logic sawValid;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        ALUctrl   = 4'b0000;
        input1    = '0;
        input2    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out", 64'(out), 64'd0);
        checkOutput("rst_hi", 64'(out_hi), 64'd0);
        checkOutput("rst_ovf", 64'(Overflow), 64'd0);

        singleOp("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 1'b0, 1'b1);
        singleOp("sub_zero", 4'b0110, 32'd5, 32'd5, 32'h0, 32'h0, 1'b1, 1'b0);
        singleOp("slt", 4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0);
        singleOp("sltu", 4'b1000, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0);
        singleOp("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1);
        singleOp("and", 4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 32'h0, 1'b0, 1'b0);
        singleOp("or", 4'b0001, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 32'h0, 1'b0, 1'b0);
        singleOp("nor", 4'b1100, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, 32'h0, 1'b0, 1'b0);
        singleOp("undef", 4'b0101, 32'h1234_5678, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0);

        applyStimulus(4'b0011, 32'h0001_0000, 32'h0001_0000);
        waitValid(lat, readySeen);
        checkOutput("mul_latency", 64'(lat), 64'd33);
        checkOutput("mul_busy_ready", 64'(readySeen), 64'd0);
        checkOutput("mul_out", 64'(out), 64'h0);
        checkOutput("mul_hi", 64'(out_hi), 64'h1);
        checkOutput("mul_zero", 64'(Zero), 64'd1);
        @(posedge clk);
        #1;

        applyStimulus(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitValid(lat, readySeen);
        checkOutput("mulmax_latency", 64'(lat), 64'd33);
        checkOutput("mulmax_out", 64'(out), 64'h0000_0001);
        checkOutput("mulmax_hi", 64'(out_hi), 64'hFFFF_FFFE);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        applyStimulus(4'b0100, 32'd100, 32'd7);
        waitValid(lat, readySeen);
        checkOutput("div_latency", 64'(lat), 64'd33);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("div_hold_valid", 64'(out_valid), 64'd1);
            checkOutput("div_hold_out", 64'(out), 64'd14);
            checkOutput("div_hold_hi", 64'(out_hi), 64'd2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("div_release_ready", 64'(in_ready), 64'd1);
        checkOutput("div_release_valid", 64'(out_valid), 64'd0);

        applyStimulus(4'b0100, 32'hFFFF_FFFF, 32'h0000_0010);
        waitValid(lat, readySeen);
        checkOutput("div2_out", 64'(out), 64'h0FFF_FFFF);
        checkOutput("div2_hi", 64'(out_hi), 64'hF);
        @(posedge clk);
        #1;

        singleOp("div0", 4'b0100, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b0, 1'b0);

        applyStimulus(4'b0011, 32'd3, 32'd4);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_out", 64'(out), 64'h0);
        checkOutput("abort_hi", 64'(out_hi), 64'h0);
        checkOutput("abort_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_ovf", 64'(Overflow), 64'd0);
        checkOutput("abort_ready", 64'(in_ready), 64'd1);
        sawValid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("abort_no_result", 64'(sawValid), 64'd0);

        singleOp("add_after", 4'b0010, 32'd2, 32'd3, 32'd5, 32'h0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
